seg_wr_sched: RTL and testbench
===============================

Name: seg_wr_sched

Overview:
- Scheduler for the single write port of the 8-entry x 16-bit segment register file.
- Arbitrates write requests from several producers and drives the regfile wr_en/wr_reg/wr_data one cycle after acceptance.
- Producers: writeback MOV/POP Sreg, far-branch CS loader, exception unit.
- Keeps a per-segment pending scoreboard for decode stall logic.
- After any CS write, sequences a fetch flush and holds off further writes.

Parameters:
- NREQ, 3: number of requesters; index NREQ-1 has highest priority.
- CS_HOLD_CYCLES, 2: cycles in CS_HOLD after a CS write (legal range 1..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester write request.
- req_reg  in  3*NREQ  target segment index; slice i = [3i+2:3i].
- req_data  in  16*NREQ  write data; slice i = [16i+15:16i].
- req_ready  out  NREQ  one-hot grant; a transfer occurs when valid&ready.
- seg_wr_en  out  1  regfile write enable.
- seg_wr_reg  out  3  regfile write index.
- seg_wr_data  out  16  regfile write data.
- seg_busy  out  8  bit r set while a write to segment r is staged or driving.
- cs_flush  out  1  one-cycle pulse: CS changed, redirect fetch.
- hold_active  out  1  high during CS_HOLD.

Behaviour:
- Reset (async, rst=1): state IDLE, hold counter 0. seg_wr_en=0, seg_wr_reg=0, seg_wr_data=0, seg_busy=0, cs_flush=0, hold_active=0. req_ready=0 while rst is high.
- States: IDLE, WRITE, CS_HOLD. Encoding comes from the package.
- Grant window (`can_accept`):
  - Active in IDLE.
  - Active in WRITE when the staged reg != CS (index 1).
  - When active, req_ready is the fixed-priority one-hot of req_valid; highest index wins.
  - Otherwise req_ready=0.
  - req_ready depends on req_valid combinationally; producers must not make req_valid depend on req_ready.
- Accept: on a transfer, the granted reg/data are registered into the stage. Next cycle: state=WRITE, seg_wr_en=1, seg_wr_reg/seg_wr_data = the staged values. Latency is exactly 1 cycle from accept edge to write cycle.
- Throughput: back-to-back non-CS writes at 1 per cycle.
- WRITE transitions:
  - Staged reg==1 → CS_HOLD, counter=CS_HOLD_CYCLES, cs_flush=1 in the first CS_HOLD cycle only.
  - Otherwise, new accept this cycle → WRITE.
  - Otherwise → IDLE.
- CS_HOLD:
  - seg_wr_en=0, hold_active=1, no grants.
  - Counter decrements each cycle; at 1 → IDLE.
  - Total hold is CS_HOLD_CYCLES cycles.
- seg_busy:
  - Decoded from the staged reg while state==WRITE; 0 otherwise.
  - A new accept to the same reg keeps the bit set continuously.
- Simultaneous valids: only the winner is readied. Losers keep valid asserted with stable reg/data until granted.
- Starvation: fixed priority is intentional; low-priority starvation is acceptable.
- Reset mid-operation: staged write is dropped (never reaches the regfile), hold is aborted, no cs_flush is emitted.
- All 8 indices are writable. Only index 1 triggers the CS sequence.

Optional Feature:
- SEG_WR_BYPASS_EN defined:
  - Adds inputs rd_sel1/2/3 (3 bits each) and rd_raw1/2/3 (16 bits each, from the regfile read ports).
  - Adds outputs rd_byp1/2/3 (16 bits each).
  - When state==WRITE and rd_selN==seg_wr_reg, rd_bypN=seg_wr_data; else rd_bypN=rd_rawN. Combinational.
- Undefined: these ports are absent and readers stall on seg_busy.

Decomposition:
- Package seg_ctl_pkg holds: state enum (IDLE/WRITE/CS_HOLD), CS_IDX=3'd1, NUM_SEG=8, SEG_W=16, SEGIDX_W=3.
- Sub-module seg_prio_arb: NREQ-wide fixed-priority one-hot grant with an enable input.

Test Plan:
- Reset → all outputs 0. Release reset, req_valid[0]=1, reg=3, data=16'h1234 → req_ready[0]=1; next cycle seg_wr_en=1, wr_reg=3, wr_data=16'h1234, seg_busy=8'h08; following cycle idle.
- req_valid=3'b111 with regs 2/4/5 held → grants in order idx2, idx1, idx0 on consecutive cycles; writes to 5, 4, 2 on consecutive cycles.
- CS write, data=16'hF000, CS_HOLD_CYCLES=2 → write cycle, then cs_flush=1 for 1 cycle, hold_active=1 for 2 cycles; a competing req_valid[0] is not granted until hold ends.
- rst asserted in the cycle after a CS accept → no seg_wr_en, no cs_flush, all outputs 0 immediately.
- Back-to-back writes to reg 3 then reg 3 → seg_busy[3] high for 2 consecutive cycles with no gap.
- (SEG_WR_BYPASS_EN) rd_sel1=3 during a write of 16'hBEEF to reg 3 → rd_byp1=16'hBEEF; rd_sel2=4 → rd_byp2=rd_raw2.

Source files
------------

// File: rtl/seg_ctl_pkg.sv
// Shared types and constants for the segment register write path.
// State encoding, segment indices and a one-hot decode helper.
package seg_ctl_pkg;

  localparam int NUM_SEG  = 8;
  localparam int SEG_W    = 16;
  localparam int SEGIDX_W = 3;

  localparam logic [SEGIDX_W-1:0] CS_IDX = 3'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    CS_HOLD = 2'd2
  } state_t;

  function automatic logic [NUM_SEG-1:0] seg_onehot(input logic [SEGIDX_W-1:0] idx);
    seg_onehot      = '0;
    seg_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/seg_prio_arb.sv
// Fixed-priority one-hot arbiter; the highest index wins.
// Latency: combinational. Backpressure: no grant at all while en is low.
module seg_prio_arb
  import seg_ctl_pkg::*;
#(
  parameter int NREQ = 3
) (
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  always_comb begin
    gnt = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (en && req[i] && (gnt == '0)) gnt[i] = 1'b1;
    end
  end

endmodule

// File: rtl/seg_wr_sched.sv
// Write-port scheduler for the 8x16 segment regfile; CS writes flush fetch and hold.
// Latency: 1 cycle from accept to regfile write. Backpressure: req_ready withheld during CS write/hold.
// Optional read bypass of the in-flight write is built when SEG_WR_BYPASS_EN is defined.
module seg_wr_sched
  import seg_ctl_pkg::*;
#(
  parameter int NREQ           = 3,
  parameter int CS_HOLD_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [SEGIDX_W*NREQ-1:0] req_reg,
  input  logic [SEG_W*NREQ-1:0]    req_data,
  output logic [NREQ-1:0]          req_ready,
`ifdef SEG_WR_BYPASS_EN
  input  logic [SEGIDX_W-1:0]      rd_sel1,
  input  logic [SEGIDX_W-1:0]      rd_sel2,
  input  logic [SEGIDX_W-1:0]      rd_sel3,
  input  logic [SEG_W-1:0]         rd_raw1,
  input  logic [SEG_W-1:0]         rd_raw2,
  input  logic [SEG_W-1:0]         rd_raw3,
  output logic [SEG_W-1:0]         rd_byp1,
  output logic [SEG_W-1:0]         rd_byp2,
  output logic [SEG_W-1:0]         rd_byp3,
`endif
  output logic                     seg_wr_en,
  output logic [SEGIDX_W-1:0]      seg_wr_reg,
  output logic [SEG_W-1:0]         seg_wr_data,
  output logic [NUM_SEG-1:0]       seg_busy,
  output logic                     cs_flush,
  output logic                     hold_active
);

  localparam logic [3:0] HOLD_INIT = 4'(CS_HOLD_CYCLES);

  state_t                state, state_nxt;
  logic [3:0]            hold_cnt, hold_cnt_nxt;
  logic [SEGIDX_W-1:0]   stage_reg;
  logic [SEG_W-1:0]      stage_data;
  logic                  can_accept;
  logic                  accept;
  logic [SEGIDX_W-1:0]   gnt_reg;
  logic [SEG_W-1:0]      gnt_data;

  // A staged CS write closes the window so nothing lands behind it before the flush.
  assign can_accept = !rst && ((state == IDLE) ||
                               ((state == WRITE) && (stage_reg != CS_IDX)));

  seg_prio_arb #(.NREQ(NREQ)) u_arb (
    .en  (can_accept),
    .req (req_valid),
    .gnt (req_ready)
  );

  assign accept = |req_ready;

  always_comb begin
    gnt_reg  = '0;
    gnt_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        gnt_reg  = req_reg[SEGIDX_W*i +: SEGIDX_W];
        gnt_data = req_data[SEG_W*i +: SEG_W];
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    case (state)
      IDLE: begin
        if (accept) state_nxt = WRITE;
      end
      WRITE: begin
        if (stage_reg == CS_IDX) begin
          state_nxt    = CS_HOLD;
          hold_cnt_nxt = HOLD_INIT;
        end else if (accept) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = IDLE;
        end
      end
      CS_HOLD: begin
        if (hold_cnt <= 4'd1) begin
          state_nxt    = IDLE;
          hold_cnt_nxt = 4'd0;
        end else begin
          hold_cnt_nxt = hold_cnt - 4'd1;
        end
      end
      default: begin
        state_nxt    = IDLE;
        hold_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      hold_cnt   <= 4'd0;
      stage_reg  <= '0;
      stage_data <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      if (accept) begin
        stage_reg  <= gnt_reg;
        stage_data <= gnt_data;
      end
    end
  end

  assign seg_wr_en   = (state == WRITE);
  assign seg_wr_reg  = stage_reg;
  assign seg_wr_data = stage_data;
  assign seg_busy    = (state == WRITE) ? seg_onehot(stage_reg) : '0;
  assign hold_active = (state == CS_HOLD);
  // Counter is still at its load value only in the first hold cycle.
  assign cs_flush    = (state == CS_HOLD) && (hold_cnt == HOLD_INIT);

`ifdef SEG_WR_BYPASS_EN
  assign rd_byp1 = (seg_wr_en && (rd_sel1 == stage_reg)) ? stage_data : rd_raw1;
  assign rd_byp2 = (seg_wr_en && (rd_sel2 == stage_reg)) ? stage_data : rd_raw2;
  assign rd_byp3 = (seg_wr_en && (rd_sel3 == stage_reg)) ? stage_data : rd_raw3;
`endif

endmodule

// File: tb/tb_seg_wr_sched.sv
// Directed bench for seg_wr_sched with hand-computed expectations.
// Bypass checks are included when SEG_WR_BYPASS_EN is defined.
module tb_seg_wr_sched;

  logic        clk;
  logic        rst;
  logic [2:0]  req_valid;
  logic [8:0]  req_reg;
  logic [47:0] req_data;
  logic [2:0]  req_ready;
  logic        seg_wr_en;
  logic [2:0]  seg_wr_reg;
  logic [15:0] seg_wr_data;
  logic [7:0]  seg_busy;
  logic        cs_flush;
  logic        hold_active;
`ifdef SEG_WR_BYPASS_EN
  logic [2:0]  rd_sel1, rd_sel2, rd_sel3;
  logic [15:0] rd_raw1, rd_raw2, rd_raw3;
  logic [15:0] rd_byp1, rd_byp2, rd_byp3;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  seg_wr_sched #(.NREQ(3), .CS_HOLD_CYCLES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_reg     (req_reg),
    .req_data    (req_data),
    .req_ready   (req_ready),
`ifdef SEG_WR_BYPASS_EN
    .rd_sel1     (rd_sel1),
    .rd_sel2     (rd_sel2),
    .rd_sel3     (rd_sel3),
    .rd_raw1     (rd_raw1),
    .rd_raw2     (rd_raw2),
    .rd_raw3     (rd_raw3),
    .rd_byp1     (rd_byp1),
    .rd_byp2     (rd_byp2),
    .rd_byp3     (rd_byp3),
`endif
    .seg_wr_en   (seg_wr_en),
    .seg_wr_reg  (seg_wr_reg),
    .seg_wr_data (seg_wr_data),
    .seg_busy    (seg_busy),
    .cs_flush    (cs_flush),
    .hold_active (hold_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [2:0] r, input logic [15:0] d);
    req_reg[3*i +: 3]   = r;
    req_data[16*i +: 16] = d;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_wr_en"}, 32'(seg_wr_en), 32'd0);
    chk({tag, "_busy"},  32'(seg_busy),  32'd0);
    chk({tag, "_hold"},  32'(hold_active), 32'd0);
    chk({tag, "_flush"}, 32'(cs_flush),  32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 3'b000;
    req_reg   = '0;
    req_data  = '0;
`ifdef SEG_WR_BYPASS_EN
    rd_sel1 = 3'd0; rd_sel2 = 3'd0; rd_sel3 = 3'd0;
    rd_raw1 = 16'h1111; rd_raw2 = 16'h4444; rd_raw3 = 16'h7777;
`endif

    // Reset: outputs clear, no grant even with a request pending.
    step; step;
    req_valid = 3'b001;
    set_req(0, 3'd3, 16'h1234);
    #1;
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_wr_reg", 32'(seg_wr_reg), 32'd0);
    chk("rst_wr_data", 32'(seg_wr_data), 32'd0);
    chk_idle("rst");

    // Single write to reg 3.
    step;
    rst = 1'b0;
    #1;
    chk("single_ready", 32'(req_ready), 32'b001);
    step;
    req_valid = 3'b000;
    #1;
    chk("single_wr_en", 32'(seg_wr_en), 32'd1);
    chk("single_wr_reg", 32'(seg_wr_reg), 32'd3);
    chk("single_wr_data", 32'(seg_wr_data), 32'h1234);
    chk("single_busy", 32'(seg_busy), 32'h08);
    step;
    chk_idle("single_after");

    // Three simultaneous requesters: idx2 (reg5), idx1 (reg4), idx0 (reg2).
    set_req(0, 3'd2, 16'h0A02);
    set_req(1, 3'd4, 16'h0A04);
    set_req(2, 3'd5, 16'h0A05);
    req_valid = 3'b111;
    #1;
    chk("prio_gnt0", 32'(req_ready), 32'b100);
    step;
    req_valid = 3'b011;
    #1;
    chk("prio_wr0_reg", 32'(seg_wr_reg), 32'd5);
    chk("prio_wr0_data", 32'(seg_wr_data), 32'h0A05);
    chk("prio_gnt1", 32'(req_ready), 32'b010);
    step;
    req_valid = 3'b001;
    #1;
    chk("prio_wr1_reg", 32'(seg_wr_reg), 32'd4);
    chk("prio_busy1", 32'(seg_busy), 32'h10);
    chk("prio_gnt2", 32'(req_ready), 32'b001);
    step;
    req_valid = 3'b000;
    #1;
    chk("prio_wr2_en", 32'(seg_wr_en), 32'd1);
    chk("prio_wr2_reg", 32'(seg_wr_reg), 32'd2);
    chk("prio_wr2_data", 32'(seg_wr_data), 32'h0A02);
    step;
    chk_idle("prio_after");

    // CS write with a competing low-priority request held off until hold ends.
    set_req(1, 3'd1, 16'hF000);
    set_req(0, 3'd6, 16'h5555);
    req_valid = 3'b011;
    #1;
    chk("cs_gnt", 32'(req_ready), 32'b010);
    step;
    req_valid = 3'b001;
    #1;
    chk("cs_wr_en", 32'(seg_wr_en), 32'd1);
    chk("cs_wr_reg", 32'(seg_wr_reg), 32'd1);
    chk("cs_wr_data", 32'(seg_wr_data), 32'hF000);
    chk("cs_busy", 32'(seg_busy), 32'h02);
    chk("cs_wr_ready", 32'(req_ready), 32'd0);
    chk("cs_wr_flush", 32'(cs_flush), 32'd0);
    step;
    chk("cs_h1_flush", 32'(cs_flush), 32'd1);
    chk("cs_h1_hold", 32'(hold_active), 32'd1);
    chk("cs_h1_wr_en", 32'(seg_wr_en), 32'd0);
    chk("cs_h1_ready", 32'(req_ready), 32'd0);
    step;
    chk("cs_h2_flush", 32'(cs_flush), 32'd0);
    chk("cs_h2_hold", 32'(hold_active), 32'd1);
    chk("cs_h2_ready", 32'(req_ready), 32'd0);
    step;
    chk("cs_end_hold", 32'(hold_active), 32'd0);
    chk("cs_end_ready", 32'(req_ready), 32'b001);
    step;
    req_valid = 3'b000;
    #1;
    chk("cs_late_wr_reg", 32'(seg_wr_reg), 32'd6);
    chk("cs_late_wr_data", 32'(seg_wr_data), 32'h5555);
    step;
    chk_idle("cs_after");

    // Reset in the cycle after a CS accept drops the write and the flush.
    set_req(1, 3'd1, 16'hABCD);
    req_valid = 3'b010;
    step;
    req_valid = 3'b000;
    rst = 1'b1;
    #1;
    chk("rstmid_wr_reg", 32'(seg_wr_reg), 32'd0);
    chk("rstmid_wr_data", 32'(seg_wr_data), 32'd0);
    chk_idle("rstmid");
    step;
    chk_idle("rstmid_c1");
    rst = 1'b0;
    step;
    chk_idle("rstmid_rel");
    step;
    chk_idle("rstmid_rel2");

    // Back-to-back writes to reg 3: busy stays high with no gap.
    set_req(0, 3'd3, 16'h1111);
    req_valid = 3'b001;
    step;
    set_req(0, 3'd3, 16'h2222);
    #1;
    chk("b2b_busy0", 32'(seg_busy), 32'h08);
    chk("b2b_data0", 32'(seg_wr_data), 32'h1111);
    chk("b2b_ready", 32'(req_ready), 32'b001);
    step;
    req_valid = 3'b000;
    #1;
    chk("b2b_busy1", 32'(seg_busy), 32'h08);
    chk("b2b_data1", 32'(seg_wr_data), 32'h2222);
    step;
    chk_idle("b2b_after");

`ifdef SEG_WR_BYPASS_EN
    rd_sel1 = 3'd3;
    rd_sel2 = 3'd4;
    rd_sel3 = 3'd3;
    #1;
    chk("byp_idle1", 32'(rd_byp1), 32'h1111);
    set_req(0, 3'd3, 16'hBEEF);
    req_valid = 3'b001;
    step;
    req_valid = 3'b000;
    #1;
    chk("byp_hit1", 32'(rd_byp1), 32'hBEEF);
    chk("byp_miss2", 32'(rd_byp2), 32'h4444);
    chk("byp_hit3", 32'(rd_byp3), 32'hBEEF);
    step;
    chk("byp_after1", 32'(rd_byp1), 32'h1111);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
